mdu_iterative: RTL
==================

Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide responder.
- Serves the execute stage's start-pulse / ready handshake; the execute stage is the initiator and holds its pipeline stall while ready_o is low.
- Port names match the existing MDU instantiation, so the block drops in under `ENABLE_MDU.
- Datapath: radix-2 shift-add multiplier and restoring divider on magnitudes, with final sign correction.

Parameters:
- FAST_MUL, 0: when 1, multiplies use a single registered 32x32 product instead of 32 shift-add iterations.
- XLEN, 32: operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_i  in  1  one-cycle start pulse; operands and op are valid in the same cycle.
- MDU_op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- MDU_RS1_i  in  32  rs1 operand (forwarded value).
- MDU_RS2_i  in  32  rs2 operand (forwarded value).
- ready_o  out  1  high = no operation in flight and MDU_RD_o holds the last result.
- MDU_RD_o  out  32  result register.

Behaviour:
Reset:
- Async clear: state=IDLE, MDU_RD_o=0, iteration counter=0, all internal registers=0.
- Reset mid-operation abandons the operation with no partial write.

ready_o:
- Combinational: ready_o = (state==IDLE) && !valid_i.
- Low in the same cycle valid_i rises, so the initiator stalls immediately.
- Reads 1 out of reset.

Acceptance (edge E0, valid_i=1 in IDLE):
- Latch op, rs1, rs2. Operands are not sampled again, because the forwarding sources change after E0.
- Compute sign flags and magnitudes: signed ops take |x|; MULHSU treats rs1 as signed and rs2 as unsigned.
- Go to CHECK.

States IDLE -> CHECK -> ITER -> FIX -> IDLE:
- CHECK (E1):
  - Divide-by-zero (rs2==0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1. Go to IDLE.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000; REM result 0. Go to IDLE.
  - FAST_MUL=1 and multiply: register the product; go to FIX.
  - Otherwise load counter=31; go to ITER.
- ITER (E2..E33), one step per cycle:
  - Multiply: 64-bit accumulator; add the multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: shift the remainder left by 1 and bring in the dividend MSB; trial-subtract the divisor; keep the result if non-negative and set the quotient bit.
  - Counter decrements; at 0 go to FIX.
- FIX (E34):
  - Negate the product if the operand signs differ.
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend is negative.
  - Select low/high word or quotient/remainder per op; write MDU_RD_o; go to IDLE.

Latency (valid edge to first cycle with ready_o=1):
- Iterative ops: 35 edges.
- Special cases: 2 edges.
- FAST_MUL multiply: 3 edges.

Other rules:
- MDU_RD_o changes only on its write edge and holds until the next operation completes.
- valid_i outside IDLE is ignored; the initiator never issues one.
- Counter is 5 bits and never wraps below 0 (exit at 0).
- All arithmetic is unsigned on magnitudes. The intermediate remainder is 33 bits so the trial subtraction borrow is visible.

Decomposition:
- Shared package mdu_pkg holds:
  - typedef enum logic [2:0] mdu_op_t, with the eight funct3 encodings above;
  - typedef enum logic [1:0] mdu_state_t {IDLE, CHECK, ITER, FIX};
  - constants MDU_ITERATIONS=32 and DIV0_QUOTIENT=32'hFFFFFFFF.
- One natural sub-module: mdu_div_core, the restoring-division step register plus its 33-bit subtractor. The multiplier accumulator stays in the top level.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> MDU_RD_o=0xFFFFFFEB; ready_o low exactly 35 cycles from the valid cycle inclusive; MDU_RD_o unchanged before the FIX edge.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. Repeat with FAST_MUL=1: identical results, 3-edge latency.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; REM 7/-2 -> 1.
- Divide-by-zero: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; ready_o returns to 1 two edges after the valid edge.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; 2-edge latency.
- Assert rst_n low at ITER cycle 10 of a DIVU -> immediately state IDLE, MDU_RD_o=0, ready_o=1. After release, a MUL 3*4 -> 12 with normal latency. Operands driven to garbage after the valid cycle do not affect any result.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ITER,
        FIX
    } mdu_state_t;

    localparam int          MDU_ITERATIONS = 32;
    localparam logic [31:0] DIV0_QUOTIENT  = 32'hFFFFFFFF;

    function automatic logic is_div(input mdu_op_t op);
        return op[2];
    endfunction

    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 is unsigned for MULHSU.
    function automatic logic rs1_signed(input mdu_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_signed(input mdu_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider step register: one quotient bit per step on unsigned magnitudes.
module mdu_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] dq_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;

    // Remainder stays below the divisor, so bit XLEN of the trial is the borrow.
    assign rem_sh = {rem_q, dq_q[XLEN-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_q  <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            dq_q  <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            dq_q  <= {dq_q[XLEN-2:0], ~trial[XLEN]};
            rem_q <= trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        end
    end

    assign quotient  = dq_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide responder with start-pulse / ready handshake.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int FAST_MUL = 0,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [2:0]      MDU_op_i,
    input  logic [XLEN-1:0] MDU_RS1_i,
    input  logic [XLEN-1:0] MDU_RS2_i,
    output logic            ready_o,
    output logic [XLEN-1:0] MDU_RD_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state;
    mdu_op_t           op_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   rd_q;
    logic              neg1_q;
    logic              neg2_q;
    logic [2*XLEN-1:0] acc_q;
    logic [4:0]        cnt_q;

    mdu_op_t           op_in;
    logic              neg1_in;
    logic              neg2_in;
    logic [XLEN-1:0]   mag1_in;
    logic [XLEN-1:0]   mag2_in;

    logic              div_by_zero;
    logic              div_overflow;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   quo_mag;
    logic [XLEN-1:0]   rem_mag;
    logic [XLEN-1:0]   fix_result;

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic neg, input logic [2*XLEN-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*XLEN-1:0] full_product(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    endfunction

    assign ready_o  = (state == IDLE) && !valid_i;
    assign MDU_RD_o = rd_q;

    // Operand capture: sign flags and magnitudes from the forwarded values.
    always_comb begin
        op_in   = mdu_op_t'(MDU_op_i);
        neg1_in = rs1_signed(op_in) && MDU_RS1_i[XLEN-1];
        neg2_in = rs2_signed(op_in) && MDU_RS2_i[XLEN-1];
        mag1_in = cond_neg(neg1_in, MDU_RS1_i);
        mag2_in = cond_neg(neg2_in, MDU_RS2_i);
    end

    assign div_by_zero  = is_div(op_q) && (rs2_q == '0);
    assign div_overflow = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                          (rs1_q == INT_MIN) && (rs2_q == '1);

    // Shift-add step: the low half of acc_q starts as the multiplier and drains out.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {mul_sum, acc_q[XLEN-1:1]};

    mdu_div_core #(
        .XLEN(XLEN)
    ) u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state == IDLE) && valid_i),
        .step     ((state == ITER) && is_div(op_q)),
        .dividend (mag1_in),
        .divisor  (mag2_in),
        .quotient (quo_mag),
        .remainder(rem_mag)
    );

    always_comb begin
        logic [2*XLEN-1:0] prod;
        prod       = cond_neg_wide(neg1_q ^ neg2_q, acc_q);
        fix_result = cond_neg(neg1_q, rem_mag);
        case (op_q)
            OP_MUL:                      fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_result = cond_neg(neg1_q ^ neg2_q, quo_mag);
            default:                     fix_result = cond_neg(neg1_q, rem_mag);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_MUL;
            rs1_q   <= '0;
            rs2_q   <= '0;
            mcand_q <= '0;
            rd_q    <= '0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        op_q    <= op_in;
                        rs1_q   <= MDU_RS1_i;
                        rs2_q   <= MDU_RS2_i;
                        neg1_q  <= neg1_in;
                        neg2_q  <= neg2_in;
                        mcand_q <= mag1_in;
                        acc_q   <= {{XLEN{1'b0}}, mag2_in};
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (div_by_zero) begin
                        rd_q  <= op_q[1] ? rs1_q : DIV0_QUOTIENT;
                        state <= IDLE;
                    end else if (div_overflow) begin
                        rd_q  <= op_q[1] ? '0 : INT_MIN;
                        state <= IDLE;
                    end else if ((FAST_MUL != 0) && !is_div(op_q)) begin
                        acc_q <= full_product(mcand_q, acc_q[XLEN-1:0]);
                        state <= FIX;
                    end else begin
                        cnt_q <= 5'(MDU_ITERATIONS - 1);
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (!is_div(op_q)) begin
                        acc_q <= acc_step;
                    end
                    if (cnt_q == '0) begin
                        state <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    rd_q  <= fix_result;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
